// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_scan_pkg;

  typedef enum logic {
    StBlank = 1'b0,
    StShow  = 1'b1
  } scan_state_e;

  localparam logic [7:0] AN_OFF  = 8'hFF;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  function automatic logic [7:0] an_onehot(input logic [2:0] idx);
    logic [7:0] sel;
    sel = 8'b1 << idx;
    return ~sel;
  endfunction

endpackage

// File: rtl/decoder_4_7.sv
// Hex nibble to active-low seven-segment glyph, segments a..g on bits 6..0.
module decoder_4_7 (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    unique case (hex_i)
      4'h0: seg_o = 7'b0000001;
      4'h1: seg_o = 7'b1001111;
      4'h2: seg_o = 7'b0010010;
      4'h3: seg_o = 7'b0000110;
      4'h4: seg_o = 7'b1001100;
      4'h5: seg_o = 7'b0100100;
      4'h6: seg_o = 7'b0100000;
      4'h7: seg_o = 7'b0001111;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0000100;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b1100000;
      4'hC: seg_o = 7'b0110001;
      4'hD: seg_o = 7'b1000010;
      4'hE: seg_o = 7'b0110000;
      4'hF: seg_o = 7'b0111000;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit multiplexed seven-segment scanner with frame-synchronous value commit.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] data,
  input  logic [7:0]  dig_en,
  output logic        commit,
  output logic [7:0]  an,
  output logic [6:0]  seg
);

  localparam int unsigned CntMax = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] ShowLast  = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);

  logic [31:0]     shadow_q, disp_q;
  logic            pend_q;
  logic [2:0]      idx_q;
  logic [CntW-1:0] cnt_q;
  scan_state_e     state_q;

  logic [3:0] nibble;
  logic [6:0] glyph;
  logic       slot_last, boundary, lzb_keep, visible;

  assign nibble = disp_q[{idx_q, 2'b00} +: 4];

  decoder_4_7 u_decoder (
    .hex_i (nibble),
    .seg_o (glyph)
  );

  always_comb begin
    lzb_keep = 1'b1;
`ifdef SEG_SCAN_LZB_EN
    // A digit is blanked only when it and every digit above it are zero.
    lzb_keep = (idx_q == 3'd0) || ((disp_q >> {idx_q, 2'b00}) != 32'd0);
`else
    lzb_keep = 1'b1;
`endif
  end

  assign slot_last = (state_q == StShow) ? (cnt_q == ShowLast) : (cnt_q == BlankLast);
  assign boundary  = (state_q == StShow) && slot_last && (idx_q == 3'd7);
  assign visible   = dig_en[idx_q] && lzb_keep;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      disp_q   <= '0;
      pend_q   <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      state_q  <= StBlank;
      commit   <= 1'b0;
      an       <= AN_OFF;
      seg      <= SEG_OFF;
    end else begin
      cnt_q <= slot_last ? '0 : cnt_q + 1'b1;
      if (slot_last) begin
        if (state_q == StShow) begin
          state_q <= StBlank;
          idx_q   <= idx_q + 3'd1;
        end else begin
          state_q <= StShow;
        end
      end

      commit <= boundary && pend_q;
      if (boundary && pend_q) begin
        disp_q <= shadow_q;
      end
      // A load coinciding with the boundary keeps pend set for the next frame.
      if (load) begin
        shadow_q <= data;
        pend_q   <= 1'b1;
      end else if (boundary) begin
        pend_q <= 1'b0;
      end

      if ((state_q == StShow) && visible) begin
        an  <= an_onehot(idx_q);
        seg <= glyph;
      end else begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with SCAN_DIV=4, BLANK_CYC=2 (frame = 48).
module tb_seg_scan_ctrl;

  localparam int Frame = 48;
  localparam int Slot  = 6;
  localparam int Blank = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [31:0] data = '0;
  logic [7:0]  dig_en = '0;
  logic        commit;
  logic [7:0]  an;
  logic [6:0]  seg;

  int n_checks = 0;
  int n_fail   = 0;

  seg_scan_ctrl #(
    .SCAN_DIV  (4),
    .BLANK_CYC (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .data   (data),
    .dig_en (dig_en),
    .commit (commit),
    .an     (an),
    .seg    (seg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  // Expected {an, seg} for the state at frame offset o.
  function automatic logic [14:0] exp_out(input int o, input logic [7:0] en, input logic [31:0] dv);
    int k;
    logic ok, lit;
    logic [7:0] sel;
    k = o / Slot;
`ifdef SEG_SCAN_LZB_EN
    ok = (k == 0) || ((dv >> (4 * k)) != 32'd0);
`else
    ok = 1'b1;
`endif
    lit = ((o % Slot) >= Blank) && en[k] && ok;
    sel = 8'd1 << k;
    if (lit) return {~sel, glyph(dv[4*k +: 4])};
    return {8'hFF, 7'h7F};
  endfunction

  // Runs one frame from its first cycle; outputs checked reflect this frame's states.
  task automatic run_frame(input string tag, input logic [7:0] en, input logic [31:0] dv,
                           input int ld_a, input logic [31:0] va,
                           input int ld_b, input logic [31:0] vb, input logic exp_commit);
    logic [14:0] e;
    for (int o = 0; o < Frame; o++) begin
      dig_en = en;
      load   = (o == ld_a) || (o == ld_b);
      data   = (o == ld_b) ? vb : va;
      tick();
      load = 1'b0;
      e = exp_out(o, en, dv);
      check_eq($sformatf("%s_an_o%0d", tag, o), {24'd0, an}, {24'd0, e[14:7]});
      check_eq($sformatf("%s_seg_o%0d", tag, o), {25'd0, seg}, {25'd0, e[6:0]});
      check_eq($sformatf("%s_commit_o%0d", tag, o), {31'd0, commit},
               {31'd0, (o == Frame - 1) ? exp_commit : 1'b0});
    end
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_an", {24'd0, an}, 32'hFF);
    check_eq("rst_seg", {25'd0, seg}, 32'h7F);
    check_eq("rst_commit", {31'd0, commit}, 32'd0);

    run_frame("idle", 8'h00, 32'h0, -1, 32'h0, -1, 32'h0, 1'b0);
    run_frame("load1", 8'hFF, 32'h0, 3, 32'h1234_5678, -1, 32'h0, 1'b1);
    run_frame("b2b", 8'hFF, 32'h1234_5678, 10, 32'hAAAA_AAAA, 15, 32'hFFFF_FFFF, 1'b1);
    run_frame("bnd", 8'hFF, 32'hFFFF_FFFF, 20, 32'h1357_9BDF, 47, 32'h2468_ACE0, 1'b1);
    run_frame("bnd2", 8'hFF, 32'h1357_9BDF, -1, 32'h0, -1, 32'h0, 1'b1);
    run_frame("ld8", 8'hFF, 32'h2468_ACE0, 0, 32'h8888_8888, -1, 32'h0, 1'b1);
    run_frame("en05", 8'h05, 32'h8888_8888, -1, 32'h0, -1, 32'h0, 1'b0);

    // Partial frame with a pending load, then reset in the middle of digit 3's SHOW.
    for (int o = 0; o <= 20; o++) begin
      dig_en = 8'hFF;
      load   = (o == 4);
      data   = 32'hDEAD_BEEF;
      tick();
      load = 1'b0;
    end
    check_eq("mid_an", {24'd0, an}, 32'hF7);
    check_eq("mid_seg", {25'd0, seg}, {25'd0, 7'b0000000});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mrst_an", {24'd0, an}, 32'hFF);
    check_eq("mrst_seg", {25'd0, seg}, 32'h7F);
    check_eq("mrst_commit", {31'd0, commit}, 32'd0);

    run_frame("post_rst", 8'hFF, 32'h0, -1, 32'h0, -1, 32'h0, 1'b0);
    run_frame("ld_a0", 8'hFF, 32'h0, 5, 32'h0000_00A0, -1, 32'h0, 1'b1);
    run_frame("show_a0", 8'hFF, 32'h0000_00A0, -1, 32'h0, -1, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
